// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus bundle: instruction-memory port plus the decode-side
// valid/ready handshake and the redirect inputs for the head instruction.
interface fetch_prefetch_queue_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic [31:0] NextInstruct;
  logic        InstrValid;
  logic        InstrReady;
  logic        BranchTaken;
  logic [31:0] BranchOffset;
  logic        Jump;
  logic        JumpSel;
  logic [31:0] JumpRegister;

  modport master (
    output IMemReq, IMemAddr, Instruction, NextInstruct, InstrValid,
    input  IMemData, InstrReady, BranchTaken, BranchOffset, Jump, JumpSel, JumpRegister
  );

  modport slave (
    input  IMemReq, IMemAddr, Instruction, NextInstruct, InstrValid,
    output IMemData, InstrReady, BranchTaken, BranchOffset, Jump, JumpSel, JumpRegister
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Pipelined instruction fetch: issues one-cycle-latency reads, buffers words
// with their link value, and flushes/refetches when the consumed head redirects.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                    Clk,
  input logic                    Reset,
  fetch_prefetch_queue_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] link;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] occupancy;
  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_link;
  logic          inflight;
  logic          pop, push, redirect, issue;
  logic [31:0]   target;

  assign head             = mem[rd_ptr];
  assign bus.InstrValid   = (count != '0);
  assign bus.Instruction  = bus.InstrValid ? head.instr : '0;
  assign bus.NextInstruct = bus.InstrValid ? head.link  : '0;

  assign pop      = bus.InstrValid & bus.InstrReady;
  assign push     = inflight;
  assign redirect = pop & (bus.Jump | bus.BranchTaken);

  // Slots already promised (buffered + in flight) after this cycle's pop.
  assign occupancy = (AW+2)'(count) + (AW+2)'(inflight) - (AW+2)'(pop);
  assign issue     = !Reset && !redirect && (occupancy < (AW+2)'(DEPTH));

  assign bus.IMemReq  = issue;
  assign bus.IMemAddr = fetch_pc;

  always_comb begin
    target = head.link + (bus.BranchOffset << 2);
    if (bus.Jump) begin
      target = bus.JumpSel ? (bus.JumpRegister & ~32'd3)
                           : {head.link[31:28], head.instr[25:0], 2'b00};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_pc      <= RESET_PC;
      inflight      <= 1'b0;
      inflight_link <= '0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else begin
      inflight_link <= fetch_pc + 32'd4;
      inflight      <= issue;
      if (redirect) begin
        // Flushing with inflight cleared drops the response arriving now.
        fetch_pc <= target;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  wr_ptr   <= wr_ptr + AW'(1);
        if (pop)   rd_ptr   <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge Clk) begin
    if (push && !redirect) mem[wr_ptr] <= '{instr: bus.IMemData, link: inflight_link};
  end

  overflow_check: assert property (@(posedge Clk) disable iff (Reset)
    !(push && !pop && !redirect && count == (AW+1)'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench: program-order reference model (expected next PC) plus
// directed latency/stall/redirect scenarios and a randomized redirect phase.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic Clk;
  logic Reset;
  fetch_prefetch_queue_if bus ();

  fetch_prefetch_queue #(.DEPTH(2), .RESET_PC(RESET_PC)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  bit          popped;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory image: word i holds i+1, except a NOP at 0x20 and a J-format word at 0x1000_0004.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'h0000_0040;
    if (a == 32'h0000_0020) return 32'h0000_0000;
    return (a >> 2) + 32'd1;
  endfunction

  always @(posedge Clk) bus.IMemData <= bus.IMemReq ? word(bus.IMemAddr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, advance the model on a pop.
  task automatic cycle(input logic rdy, input logic br = 1'b0, input logic [31:0] off = '0,
                       input logic jmp = 1'b0, input logic sel = 1'b0, input logic [31:0] jr = '0);
    logic [31:0] w, link;
    @(negedge Clk);
    bus.InstrReady   = rdy;
    bus.BranchTaken  = br;
    bus.BranchOffset = off;
    bus.Jump         = jmp;
    bus.JumpSel      = sel;
    bus.JumpRegister = jr;
    #1;
    popped = 1'b0;
    if (bus.IMemReq) check("addr_align", {30'd0, bus.IMemAddr[1:0]}, 32'd0);
    if (bus.InstrValid) begin
      w    = word(exp_pc);
      link = exp_pc + 32'd4;
      check("head_instr", bus.Instruction, w);
      check("head_link", bus.NextInstruct, link);
      if (rdy) begin
        popped = 1'b1;
        if (jmp)     exp_pc = sel ? {jr[31:2], 2'b00} : {link[31:28], w[25:0], 2'b00};
        else if (br) exp_pc = link + (off << 2);
        else         exp_pc = link;
      end
    end
  endtask

  // Reset pulse asserted mid-cycle, then the c0/c1/c2 start-up latency checks.
  task automatic do_reset(input logic rdy);
    @(negedge Clk);
    Reset = 1'b1;
    bus.InstrReady = 1'b0; bus.BranchTaken = 1'b0; bus.Jump = 1'b0;
    #1;
    check("rst_valid", bus.InstrValid, 0);
    check("rst_req", bus.IMemReq, 0);
    check("rst_instr", bus.Instruction, 0);
    check("rst_link", bus.NextInstruct, 0);
    repeat (2) begin
      @(negedge Clk); #1;
      check("rst_hold_req", bus.IMemReq, 0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    bus.InstrReady = rdy;
    exp_pc = RESET_PC;
    #1;
    check("c0_req", bus.IMemReq, 1);
    check("c0_addr", bus.IMemAddr, RESET_PC);
    check("c0_valid", bus.InstrValid, 0);
    cycle(rdy);
    check("c1_valid", bus.InstrValid, 0);
    cycle(rdy);
    check("c2_valid", bus.InstrValid, 1);
  endtask

  task automatic advance_to(input logic [31:0] pc);
    for (int i = 0; i < 64 && exp_pc != pc; i++) cycle(1'b1);
    check("reach_pc", exp_pc, pc);
  endtask

  // Pop the head with redirect inputs, then verify the t+1/t+2/t+3 timing; head left unpopped.
  task automatic pop_redirect(input logic br, input logic [31:0] off, input logic jmp,
                              input logic sel, input logic [31:0] jr, input logic [31:0] tgt);
    bit done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      cycle(1'b1, br, off, jmp, sel, jr);
      done = popped;
    end
    check("redir_popped", {31'd0, done}, 1);
    cycle(1'b1);
    check("t1_req", bus.IMemReq, 1);
    check("t1_addr", bus.IMemAddr, tgt);
    check("t1_valid", bus.InstrValid, 0);
    cycle(1'b1);
    check("t2_valid", bus.InstrValid, 0);
    cycle(1'b0);
    check("t3_valid", bus.InstrValid, 1);
    check("t3_instr", bus.Instruction, word(tgt));
  endtask

  initial begin
    Reset = 1'b1;
    bus.InstrReady = 1'b0; bus.BranchTaken = 1'b0; bus.BranchOffset = '0;
    bus.Jump = 1'b0; bus.JumpSel = 1'b0; bus.JumpRegister = '0;
    exp_pc = RESET_PC;

    // Streaming from reset: one word per cycle, including the NOP at 0x20.
    do_reset(1'b1);
    repeat (10) begin
      cycle(1'b1);
      check("stream_valid", bus.InstrValid, 1);
    end

    // Back-pressure: queue fills to DEPTH, requests stop, head holds, then drains in order.
    do_reset(1'b0);
    check("full_req_c2", bus.IMemReq, 0);
    repeat (5) begin
      cycle(1'b0);
      check("stall_req", bus.IMemReq, 0);
      check("stall_valid", bus.InstrValid, 1);
    end
    repeat (8) cycle(1'b1);

    // Backward branch from 0x10 to 0x04; 0x14/0x18 must never appear.
    do_reset(1'b1);
    advance_to(32'h10);
    pop_redirect(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0, 32'h0000_0004);

    // JR into the 0x1000_0000 region, J with region bits, then JR with low bits masked.
    pop_redirect(1'b0, '0, 1'b1, 1'b1, 32'h1000_0004, 32'h1000_0004);
    pop_redirect(1'b0, '0, 1'b1, 1'b0, '0, 32'h1000_0100);
    pop_redirect(1'b0, '0, 1'b1, 1'b1, 32'h0000_0203, 32'h0000_0200);

    // Redirect inputs held while stalled are ignored; at the pop Jump beats BranchTaken.
    repeat (3) begin
      cycle(1'b0, 1'b1, 32'd5, 1'b1, 1'b1, 32'h300);
      check("held_req", bus.IMemReq, 0);
    end
    pop_redirect(1'b1, 32'd5, 1'b1, 1'b1, 32'h300, 32'h0000_0300);

    // Reset one cycle after a redirect pop: restart at RESET_PC, nothing from 0x344.
    cycle(1'b1, 1'b1, 32'h10);
    check("pre_reset_pop", {31'd0, popped}, 1);
    do_reset(1'b1);
    repeat (4) cycle(1'b1);

    // Randomized back-pressure, branches, jumps and occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic        rdy, br, jmp, sel;
      logic [5:0]  o;
      int unsigned k;
      if ($urandom_range(0, 149) == 0) do_reset(1'($urandom_range(0, 1)));
      rdy = ($urandom_range(0, 99) < 75);
      k   = $urandom_range(0, 15);
      jmp = (k <= 1);
      sel = (k == 1);
      br  = (k >= 2 && k <= 4);
      o   = 6'($urandom);
      cycle(rdy, br, {{26{o[5]}}, o}, jmp, sel, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
